// File: rtl/decode_cycle.sv
// Decode stage of a five-stage MIPS-like pipeline: register file with write-first bypass,
// control decode, load-use / branch hazard detection, jump and branch resolution, ID/EX register.
module decode_cycle #(
  parameter logic [31:0] SP_INIT = 32'h00000FFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_npc,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_rd,
  output logic        stall,
  output logic        flush_if,
  output logic [1:0]  pc_src,
  output logic [31:0] jump_address,
  output logic [31:0] branch_address,
  output logic        idex_valid,
  output logic [31:0] idex_npc,
  output logic [31:0] idex_rs_data,
  output logic [31:0] idex_rt_data,
  output logic [31:0] idex_imm,
  output logic [4:0]  idex_rs,
  output logic [4:0]  idex_rt,
  output logic [4:0]  idex_rd,
  output logic [5:0]  idex_funct,
  output logic        idex_reg_write,
  output logic        idex_mem_read,
  output logic        idex_mem_write,
  output logic        idex_alu_src,
  output logic        idex_illegal
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  function automatic logic signed [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  logic [31:0] regs [32];

  logic [5:0]         opcode_p0;
  logic [4:0]         rs_p0, rt_p0, rd_p0, dest_p0;
  logic [5:0]         funct_p0;
  logic signed [31:0] imm_p0;
  logic [31:0]        rs_data_p0, rt_data_p0;
  logic               is_r, is_addi, is_lw, is_sw, is_beq, is_j;
  logic               load_use, rs_dep, rt_dep, branch_stall;

  assign opcode_p0 = if_instr[31:26];
  assign rs_p0     = if_instr[25:21];
  assign rt_p0     = if_instr[20:16];
  assign rd_p0     = if_instr[15:11];
  assign funct_p0  = if_instr[5:0];
  assign imm_p0    = sext16(if_instr[15:0]);

  assign is_r    = (opcode_p0 == OP_R);
  assign is_addi = (opcode_p0 == OP_ADDI);
  assign is_lw   = (opcode_p0 == OP_LW);
  assign is_sw   = (opcode_p0 == OP_SW);
  assign is_beq  = (opcode_p0 == OP_BEQ);
  assign is_j    = (opcode_p0 == OP_J);

  assign jump_address   = {if_npc[31:28], if_instr[25:0], 2'b00};
  assign branch_address = if_npc + {imm_p0[29:0], 2'b00};

  // Register file; r0 is never written and always read back as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= (i == 29) ? SP_INIT : 32'd0;
    end else if (wb_we && wb_addr != 5'd0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs_data_p0 = regs[rs_p0];
    rt_data_p0 = regs[rt_p0];
    if (rs_p0 == 5'd0) rs_data_p0 = 32'd0;
    else if (wb_we && wb_addr == rs_p0) rs_data_p0 = wb_data;
    if (rt_p0 == 5'd0) rt_data_p0 = 32'd0;
    else if (wb_we && wb_addr == rt_p0) rt_data_p0 = wb_data;
  end

  always_comb begin
    dest_p0 = 5'd0;
    if (is_r) dest_p0 = rd_p0;
    else if (is_addi || is_lw) dest_p0 = rt_p0;
  end

  // Hazards: a load result is not ready for decode; BEQ compares in decode so it needs both
  // operands already written back
  always_comb begin
    load_use = idex_valid && idex_mem_read && (idex_rd != 5'd0) &&
               ((idex_rd == rs_p0) || ((idex_rd == rt_p0) && (is_r || is_beq || is_sw)));
    rs_dep   = (rs_p0 != 5'd0) && ((idex_reg_write && idex_rd == rs_p0) ||
                                   (exmem_reg_write && exmem_rd == rs_p0));
    rt_dep   = (rt_p0 != 5'd0) && ((idex_reg_write && idex_rd == rt_p0) ||
                                   (exmem_reg_write && exmem_rd == rt_p0));
    branch_stall = is_beq && (rs_dep || rt_dep);
    stall  = !rst && if_valid && (load_use || branch_stall);
    pc_src = 2'b00;
    if (!rst && if_valid && !stall) begin
      if (is_j) pc_src = 2'b01;
      else if (is_beq && rs_data_p0 == rt_data_p0) pc_src = 2'b10;
    end
    flush_if = (pc_src != 2'b00);
  end

  // ---- ID/EX boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst || !if_valid || stall) begin
      idex_valid     <= 1'b0;
      idex_npc       <= 32'd0;
      idex_rs_data   <= 32'd0;
      idex_rt_data   <= 32'd0;
      idex_imm       <= 32'd0;
      idex_rs        <= 5'd0;
      idex_rt        <= 5'd0;
      idex_rd        <= 5'd0;
      idex_funct     <= 6'd0;
      idex_reg_write <= 1'b0;
      idex_mem_read  <= 1'b0;
      idex_mem_write <= 1'b0;
      idex_alu_src   <= 1'b0;
      idex_illegal   <= 1'b0;
    end else begin
      idex_valid     <= 1'b1;
      idex_npc       <= if_npc;
      idex_rs_data   <= rs_data_p0;
      idex_rt_data   <= rt_data_p0;
      idex_imm       <= imm_p0;
      idex_rs        <= rs_p0;
      idex_rt        <= rt_p0;
      idex_rd        <= dest_p0;
      idex_funct     <= funct_p0;
      idex_reg_write <= is_r || is_addi || is_lw;
      idex_mem_read  <= is_lw;
      idex_mem_write <= is_sw;
      idex_alu_src   <= is_addi || is_lw || is_sw;
      idex_illegal   <= !(is_r || is_addi || is_lw || is_sw || is_beq || is_j);
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: directed scenarios plus randomized traffic against a
// behavioural model of the decode stage (register array, hazard rules, ID/EX contents).
module tb_decode_cycle;

  localparam logic [31:0] SP = 32'h00000FFC;

  typedef struct packed {
    logic        valid;
    logic [31:0] npc, rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic        rw, mr, mw, as, ill;
  } idex_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, wb_we, exmem_reg_write;
  logic [31:0] if_instr, if_npc, wb_data;
  logic [4:0]  wb_addr, exmem_rd;
  logic        stall, flush_if;
  logic [1:0]  pc_src;
  logic [31:0] jump_address, branch_address;
  logic        idex_valid, idex_reg_write, idex_mem_read, idex_mem_write, idex_alu_src, idex_illegal;
  logic [31:0] idex_npc, idex_rs_data, idex_rt_data, idex_imm;
  logic [4:0]  idex_rs, idex_rt, idex_rd;
  logic [5:0]  idex_funct;

  int    n_checks = 0;
  int    n_errors = 0;
  logic [31:0] mregs [32];
  idex_t e;
  logic  last_st = 1'b0;

  always #5 clk = ~clk;

  decode_cycle #(.SP_INIT(SP)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_npc(if_npc),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .stall(stall), .flush_if(flush_if), .pc_src(pc_src),
    .jump_address(jump_address), .branch_address(branch_address),
    .idex_valid(idex_valid), .idex_npc(idex_npc), .idex_rs_data(idex_rs_data),
    .idex_rt_data(idex_rt_data), .idex_imm(idex_imm), .idex_rs(idex_rs), .idex_rt(idex_rt),
    .idex_rd(idex_rd), .idex_funct(idex_funct), .idex_reg_write(idex_reg_write),
    .idex_mem_read(idex_mem_read), .idex_mem_write(idex_mem_write),
    .idex_alu_src(idex_alu_src), .idex_illegal(idex_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int s, input int t, input int d, input int fn);
    return {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int s, input int t, input int imm);
    return {6'(op), 5'(s), 5'(t), 16'(imm)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = (i == 29) ? SP : 32'd0;
    e = '0;
  endtask

  function automatic logic [31:0] mread(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_we && wb_addr == idx) return wb_data;
    return mregs[idx];
  endfunction

  function automatic logic model_stall();
    int op, s, t;
    logic lu, bs;
    op = int'(if_instr[31:26]);
    s  = int'(if_instr[25:21]);
    t  = int'(if_instr[20:16]);
    lu = e.valid && e.mr && e.rd != 0 &&
         (int'(e.rd) == s || (int'(e.rd) == t && (op == 0 || op == 4 || op == 43)));
    bs = 1'b0;
    if (op == 4) begin
      if (s != 0 && ((e.rw && int'(e.rd) == s) || (exmem_reg_write && int'(exmem_rd) == s))) bs = 1'b1;
      if (t != 0 && ((e.rw && int'(e.rd) == t) || (exmem_reg_write && int'(exmem_rd) == t))) bs = 1'b1;
    end
    return if_valid && (lu || bs);
  endfunction

  function automatic logic [1:0] model_pc_src(input logic st);
    if (!if_valid || st) return 2'b00;
    if (if_instr[31:26] == 6'd2) return 2'b01;
    if (if_instr[31:26] == 6'd4 && mread(if_instr[25:21]) == mread(if_instr[20:16])) return 2'b10;
    return 2'b00;
  endfunction

  function automatic idex_t model_next(input logic st);
    idex_t n;
    int    simm;
    n = '0;
    if (!if_valid || st) return n;
    simm    = $signed(if_instr[15:0]);
    n.valid = 1'b1;
    n.npc   = if_npc;
    n.rsd   = mread(if_instr[25:21]);
    n.rtd   = mread(if_instr[20:16]);
    n.imm   = 32'(simm);
    n.rs    = if_instr[25:21];
    n.rt    = if_instr[20:16];
    n.funct = if_instr[5:0];
    case (if_instr[31:26])
      6'd0:  begin n.rw = 1'b1; n.rd = if_instr[15:11]; end
      6'd8:  begin n.rw = 1'b1; n.as = 1'b1; n.rd = if_instr[20:16]; end
      6'd35: begin n.rw = 1'b1; n.mr = 1'b1; n.as = 1'b1; n.rd = if_instr[20:16]; end
      6'd43: begin n.mw = 1'b1; n.as = 1'b1; end
      6'd4, 6'd2: ;
      default: n.ill = 1'b1;
    endcase
    return n;
  endfunction

  task automatic check_idex();
    chk("idex_valid", 32'(idex_valid), 32'(e.valid));
    chk("idex_npc", idex_npc, e.npc);
    chk("idex_rs_data", idex_rs_data, e.rsd);
    chk("idex_rt_data", idex_rt_data, e.rtd);
    chk("idex_imm", idex_imm, e.imm);
    chk("idex_rs", 32'(idex_rs), 32'(e.rs));
    chk("idex_rt", 32'(idex_rt), 32'(e.rt));
    chk("idex_rd", 32'(idex_rd), 32'(e.rd));
    chk("idex_funct", 32'(idex_funct), 32'(e.funct));
    chk("idex_reg_write", 32'(idex_reg_write), 32'(e.rw));
    chk("idex_mem_read", 32'(idex_mem_read), 32'(e.mr));
    chk("idex_mem_write", 32'(idex_mem_write), 32'(e.mw));
    chk("idex_alu_src", 32'(idex_alu_src), 32'(e.as));
    chk("idex_illegal", 32'(idex_illegal), 32'(e.ill));
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] npc,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic xw, input logic [4:0] xr);
    if_valid = v; if_instr = instr; if_npc = npc;
    wb_we = we; wb_addr = wa; wb_data = wd;
    exmem_reg_write = xw; exmem_rd = xr;
    #1;
  endtask

  // Called 1 time unit after a negedge drive; returns at the following negedge
  task automatic cycle();
    logic       st;
    logic [1:0] ps;
    idex_t      nx;
    int         simm;
    st   = model_stall();
    ps   = model_pc_src(st);
    simm = $signed(if_instr[15:0]);
    chk("stall", 32'(stall), 32'(st));
    chk("pc_src", 32'(pc_src), 32'(ps));
    chk("flush_if", 32'(flush_if), 32'(ps != 2'b00));
    chk("jump_address", jump_address, {if_npc[31:28], if_instr[25:0], 2'b00});
    chk("branch_address", branch_address, if_npc + 32'(simm * 4));
    nx = model_next(st);
    last_st = st;
    @(posedge clk);
    e = nx;
    if (wb_we && wb_addr != 5'd0) mregs[wb_addr] = wb_data;
    @(negedge clk);
    check_idex();
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] ri;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);

    // In reset: hazard and jump conditions present, coincident writeback to r3
    drive(1, itype(4, 1, 2, 0), 32'h100, 1, 5'd3, 32'hAAAA5555, 1, 5'd1);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_pc_src", 32'(pc_src), 0);
    check_idex();
    drive(1, {6'b000010, 26'h40}, 32'h100, 1, 5'd3, 32'hAAAA5555, 0, 0);
    chk("rst_jump_pc_src", 32'(pc_src), 0);
    chk("rst_flush_if", 32'(flush_if), 0);
    @(posedge clk); @(negedge clk);
    check_idex();
    rst = 1'b0;

    drive(1, rtype(29, 3, 4, 6'h20), 32'h4, 0, 0, 0, 0, 0);
    cycle();
    chk("sp_init", idex_rs_data, SP);
    chk("rst_write_dropped", idex_rt_data, 0);

    drive(1, rtype(5, 0, 6, 6'h20), 32'h10, 1, 5'd5, 32'hDEADBEEF, 0, 0);
    cycle();
    chk("bypass_rs", idex_rs_data, 32'hDEADBEEF);
    drive(1, rtype(5, 0, 7, 6'h21), 32'h14, 0, 0, 0, 0, 0);
    cycle();
    chk("r5_stored", idex_rs_data, 32'hDEADBEEF);
    drive(1, rtype(0, 0, 1, 6'h20), 32'h18, 1, 5'd0, 32'hFFFFFFFF, 0, 0);
    cycle();
    chk("r0_bypass", idex_rs_data, 0);
    drive(1, rtype(0, 0, 1, 6'h20), 32'h1C, 0, 0, 0, 0, 0);
    cycle();
    chk("r0_read", idex_rs_data, 0);

    // Load-use: one stall cycle, one bubble, then the ADD
    drive(1, itype(35, 0, 8, 4), 32'h20, 0, 0, 0, 0, 0);
    cycle();
    drive(1, rtype(8, 9, 10, 6'h20), 32'h24, 0, 0, 0, 0, 0);
    chk("lu_stall", 32'(stall), 1);
    cycle();
    chk("lu_bubble", 32'(idex_valid), 0);
    drive(1, rtype(8, 9, 10, 6'h20), 32'h24, 0, 0, 0, 0, 0);
    chk("lu_stall_released", 32'(stall), 0);
    cycle();
    chk("lu_add_valid", 32'(idex_valid), 1);
    chk("lu_add_rs", 32'(idex_rs), 8);

    drive(1, itype(4, 0, 0, 16'hFFFF), 32'h100, 0, 0, 0, 0, 0);
    chk("beq_pc_src", 32'(pc_src), 2);
    chk("beq_target", branch_address, 32'h000000FC);
    chk("beq_flush", 32'(flush_if), 1);
    cycle();
    chk("beq_slot_valid", 32'(idex_valid), 1);
    chk("beq_no_write", 32'(idex_reg_write), 0);

    drive(1, {6'b000010, 26'h0000040}, 32'h40000004, 0, 0, 0, 0, 0);
    chk("j_pc_src", 32'(pc_src), 1);
    chk("j_target", jump_address, 32'h40000100);
    cycle();
    chk("j_no_write", 32'(idex_reg_write), 0);

    drive(1, {6'b111111, 26'h1234567}, 32'h44, 0, 0, 0, 0, 0);
    cycle();
    chk("ill_flag", 32'(idex_illegal), 1);
    chk("ill_ctrl", {28'd0, idex_reg_write, idex_mem_read, idex_mem_write, idex_alu_src}, 0);

    // Branch depending on the instruction just ahead in ID/EX must wait
    drive(1, itype(8, 0, 12, 5), 32'h48, 0, 0, 0, 0, 0);
    cycle();
    drive(1, itype(4, 12, 0, 3), 32'h4C, 0, 0, 0, 0, 0);
    chk("br_stall", 32'(stall), 1);
    chk("br_stall_pc_src", 32'(pc_src), 0);
    cycle();

    for (int n = 0; n < 400; n++) begin
      if (!last_st) begin
        case ($urandom_range(0, 6))
          0: op = 6'd0;   1: op = 6'd8;  2: op = 6'd35;
          3: op = 6'd43;  4: op = 6'd4;  5: op = 6'd2;
          default: op = 6'($urandom);
        endcase
        ri = $urandom;
        ri[31:26] = op;
        ri[25:21] = 5'($urandom_range(0, 7));
        ri[20:16] = 5'($urandom_range(0, 7));
        ri[15:11] = 5'($urandom_range(0, 7));
      end
      drive($urandom_range(0, 7) != 0, ri, $urandom & 32'hFFFFFFFC,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
      cycle();
    end

    // Asynchronous reset in the middle of a load-use stall
    drive(1, itype(35, 0, 8, 4), 32'h80, 0, 0, 0, 0, 0);
    cycle();
    drive(1, rtype(8, 9, 10, 6'h20), 32'h84, 1, 5'd9, 32'h00001234, 0, 0);
    chk("mid_stall", 32'(stall), 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_stall", 32'(stall), 0);
    check_idex();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_valid", 32'(idex_valid), 0);
    drive(1, rtype(29, 9, 1, 6'h20), 32'h88, 0, 0, 0, 0, 0);
    cycle();
    chk("sp_init_again", idex_rs_data, SP);
    chk("rst_write_dropped2", idex_rt_data, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_cycle.md
DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
REQ-001 SHALL have parameter SP_INIT, default 32'h00000FFC, reset value of register r29.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have inputs if_valid (1), if_instr (32) and if_npc (32): the fetched instruction, its valid flag and its PC+4.
REQ-005 SHALL have inputs wb_we (1), wb_addr (5) and wb_data (32): the register-file write port from writeback.
REQ-006 SHALL have inputs exmem_reg_write (1) and exmem_rd (5): the EX/MEM destination, used for branch hazard checks.
REQ-007 SHALL have outputs stall (1), flush_if (1), pc_src (2), jump_address (32) and branch_address (32), all combinational, driving fetch.
REQ-008 SHALL have registered ID/EX outputs: idex_valid, idex_npc[31:0], idex_rs_data[31:0], idex_rt_data[31:0], idex_imm[31:0], idex_rs[4:0], idex_rt[4:0], idex_rd[4:0], idex_funct[5:0], idex_reg_write, idex_mem_read, idex_mem_write, idex_alu_src and idex_illegal.

Function
REQ-009 SHALL decode the instruction fields as opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm [15:0] and target [25:0].
REQ-010 SHALL support these opcodes:
- R-type 000000: rd written, alu_src=0.
- ADDI 001000: rt written, alu_src=1.
- LW 100011: rt written, mem_read, alu_src=1.
- SW 101011: mem_write, alu_src=1.
- BEQ 000100.
- J 000010.
REQ-011 SHALL treat any other opcode as a NOP with all control bits 0, and SHALL set idex_illegal=1 for that slot.
REQ-012 SHALL sign-extend imm to 32 bits for idex_imm.
REQ-013 SHALL hold a register file of 32 x 32 bits: r0 reads as 0, writes to r0 are ignored, one write per cycle.
REQ-014 SHALL return wb_data on a read when wb_we=1, wb_addr equals the read index, and the index is nonzero (write-first bypass).
REQ-015 SHALL compute jump_address = {if_npc[31:28], target, 2'b00}.
REQ-016 SHALL compute branch_address = if_npc + (sext(imm) << 2), modulo 2^32 with wrap ignored.
REQ-017 SHALL assert load-use stall when idex_valid and idex_mem_read are set, idex_rd is nonzero, and idex_rd equals rs, or equals rt for R-type, BEQ or SW.
REQ-018 SHALL assert branch stall for BEQ when a nonzero rs or rt matches either idex_rd with idex_reg_write set, or exmem_rd with exmem_reg_write set.
REQ-019 SHALL drive stall = if_valid AND (load-use stall OR branch stall); fetch and IF/ID SHALL hold while stall=1.
REQ-020 SHALL drive pc_src as follows, with stall taking priority over any taken jump or branch:
- 2'b01: J, when if_valid=1 and stall=0.
- 2'b10: BEQ with equal bypassed operands, when if_valid=1 and stall=0.
- 2'b00: otherwise.
REQ-021 SHALL drive flush_if = (pc_src != 2'b00), killing the instruction currently in fetch.
REQ-022 SHALL load the decoded instruction into ID/EX on every posedge with idex_valid=1 when if_valid=1 and stall=0.
REQ-023 SHALL load a bubble into ID/EX when if_valid=0 or stall=1: idex_valid, all control bits and idex_illegal = 0, data fields = 0.
REQ-024 SHALL leave taken J and BEQ in ID/EX as valid slots with idex_reg_write=0.
REQ-025 SHALL set idex_rd to rd for R-type, to rt for ADDI and LW, and to 0 otherwise.
REQ-026 SHALL have a latency of one cycle from if_instr to the ID/EX outputs; register writes SHALL be visible to a read in the same cycle (REQ-014).

Reset
REQ-027 SHALL, on rst=1 and independently of clk, clear all ID/EX outputs to 0, clear registers r1 to r31 to 0, and set r29 = SP_INIT.
REQ-028 SHALL hold that state while rst=1, with stall, pc_src and flush_if forced to 0.
REQ-029 SHALL discard a wb_we write that coincides with reset; a reset mid-stall SHALL leave idex_valid=0 after release.

Verification
REQ-030 SHALL cover register bypass:
- Stimulus: wb_we=1, wb_addr=5, wb_data=32'hDEADBEEF in the same cycle as R-type rs=5.
- Required response: next cycle idex_rs_data=32'hDEADBEEF.
- Also: a write to r0 leaves r0 reading 0.
REQ-031 SHALL cover load-use:
- Stimulus: LW rt=8, then ADD rs=8.
- Required response: stall=1 for exactly one cycle, one bubble (idex_valid=0), then the ADD appears with idex_rs=8.
REQ-032 SHALL cover a taken branch:
- Stimulus: BEQ r0,r0 with imm=16'hFFFF and if_npc=32'h100.
- Required response: pc_src=2'b10, branch_address=32'h000000FC, flush_if=1.
REQ-033 SHALL cover jump:
- Stimulus: J target=26'h0000040 with if_npc=32'h40000004.
- Required response: pc_src=2'b01, jump_address=32'h40000100.
REQ-034 SHALL cover an illegal opcode and reset:
- Stimulus: opcode 6'b111111.
- Required response: idex_illegal=1 with all control bits 0.
- Stimulus: assert rst between clock edges.
- Required response: outputs clear immediately and r29 reads SP_INIT.
